// File: rtl/jk_drive_ctrl.sv
// Drives a bank of JK flip-flops toward a requested value: one enable pulse,
// a settle window, a feedback compare, and bounded re-drives on mismatch.
module jk_drive_ctrl #(
    parameter int WIDTH     = 4,
    parameter int SETTLE    = 2,
    parameter int MAX_RETRY = 3,
    parameter int RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_mode,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    output logic             jk_en,
    input  logic [WIDTH-1:0] fb_q,
    output logic             done,
    output logic             err,
    output logic [RW-1:0]    retries
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] WAIT_LAST = SW'(SETTLE - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  tgt, snap;
    logic              mode;
    logic [RW-1:0]     rcnt;
    logic [SW-1:0]     wcnt;
    logic              fail;
    logic              match;
    logic              can_retry;

    assign match     = (fb_q == tgt);
    assign can_retry = (rcnt < RETRY_MAX);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        jk_en     = 1'b0;
        jk_j      = '0;
        jk_k      = '0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = DRIVE;
            end
            DRIVE: begin
                jk_en = 1'b1;
                // Toggle mode flips only the bits that differ from the snapshot.
                if (mode) begin
                    jk_j = tgt ^ snap;
                    jk_k = tgt ^ snap;
                end else begin
                    jk_j = tgt;
                    jk_k = ~tgt;
                end
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wcnt == WAIT_LAST) state_nxt = CHECK;
            end
            CHECK: begin
                state_nxt = (!match && can_retry) ? DRIVE : RESP;
            end
            RESP: begin
                done      = 1'b1;
                err       = fail;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tgt     <= '0;
            snap    <= '0;
            mode    <= 1'b0;
            rcnt    <= '0;
            wcnt    <= '0;
            fail    <= 1'b0;
            retries <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tgt  <= req_data;
                        mode <= req_mode;
                        snap <= fb_q;
                        rcnt <= '0;
                    end
                end
                DRIVE: wcnt <= '0;
                WAIT:  wcnt <= wcnt + 1'b1;
                CHECK: begin
                    // Retry count is published on the way into RESP so it is valid with done.
                    if (match) begin
                        fail    <= 1'b0;
                        retries <= rcnt;
                    end else if (can_retry) begin
                        rcnt <= rcnt + 1'b1;
                        snap <= fb_q;
                    end else begin
                        fail    <= 1'b1;
                        retries <= rcnt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_drive_ctrl.sv
// Bench for jk_drive_ctrl: JK bank model with per-pulse ignore mask, a
// transaction-level schedule model, and a per-cycle compare process.
module tb_jk_drive_ctrl;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int MR = 3;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_mode = 1'b0;
    logic [W-1:0]  req_data = '0;
    logic          req_ready, jk_en, done, err;
    logic [W-1:0]  jk_j, jk_k, fb_q;
    logic [RW-1:0] retries;

    jk_drive_ctrl #(.WIDTH(W), .SETTLE(S), .MAX_RETRY(MR), .RW(RW)) dut (
        .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_mode(req_mode), .jk_j(jk_j), .jk_k(jk_k),
        .jk_en(jk_en), .fb_q(fb_q), .done(done), .err(err), .retries(retries)
    );

    always #5 clk = ~clk;

    // JK bank: pulses whose index bit is set in ign_mask are ignored.
    logic [W-1:0] bank_q = '0;
    logic         load_en = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [7:0]   ign_mask = '0;
    logic [2:0]   pidx = '0;
    assign fb_q = bank_q;

    always @(posedge clk) begin
        if (load_en) bank_q <= load_val;
        else if (jk_en) begin
            if (!ign_mask[pidx]) bank_q <= (jk_j & ~bank_q) | (~jk_k & bank_q);
            pidx <= pidx + 3'd1;
        end
        if (req_valid && req_ready) pidx <= '0;
    end

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Expected schedule, indexed by cycles after the accept cycle.
    bit           e_en [0:63];
    logic [W-1:0] e_j  [0:63];
    logic [W-1:0] e_k  [0:63];
    int  done_t, e_ret, t;
    bit  e_err;
    bit  active = 1'b0;
    int  cyc = 0, acc_cnt = 0, acc_prev = 0, acc_last = 0;
    int  r_done_t, r_pulses, r_ret, r_err;
    logic [W-1:0] r_j, r_k;

    task automatic start_txn();
        logic [W-1:0] q, s, j, k;
        int d;
        for (int i = 0; i < 64; i++) begin e_en[i] = 0; e_j[i] = '0; e_k[i] = '0; end
        q = bank_q;
        s = q;
        for (int a = 0; a <= MR; a++) begin
            d = 1 + a * (S + 2);
            j = req_mode ? (req_data ^ s) : req_data;
            k = req_mode ? (req_data ^ s) : ~req_data;
            e_en[d] = 1; e_j[d] = j; e_k[d] = k;
            if (!ign_mask[a[2:0]]) q = (j & ~q) | (~k & q);
            if (q == req_data || a == MR) begin
                done_t = d + S + 2;
                e_err  = (q != req_data);
                e_ret  = a;
                break;
            end
            s = q;
        end
        r_pulses = 0;
        t        = 0;
        active   = 1;
        acc_prev = acc_last;
        acc_last = cyc;
        acc_cnt++;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!clr_n) begin
            chk("rst_en",    32'(jk_en), 0);
            chk("rst_jk",    32'({jk_j, jk_k}), 0);
            chk("rst_done",  32'({done, err}), 0);
            chk("rst_ret",   32'(retries), 0);
            chk("rst_ready", 32'(req_ready), 1);
            active = 0;
        end else begin
            if (active) begin
                t++;
                chk("en",   32'(jk_en), 32'(e_en[t]));
                chk("j",    32'(jk_j),  32'(e_j[t]));
                chk("k",    32'(jk_k),  32'(e_k[t]));
                chk("done", 32'(done),  32'(t == done_t));
                chk("err",  32'(err),   32'((t == done_t) && e_err));
                if (jk_en) begin r_pulses++; r_j = jk_j; r_k = jk_k; end
                if (done) begin r_done_t = t; r_err = 32'(err); end
                if (t <= done_t) chk("busy_ready", 32'(req_ready), 0);
                else begin
                    chk("retries", 32'(retries), 32'(e_ret));
                    r_ret  = 32'(retries);
                    active = 0;
                end
            end
            if (!active) begin
                chk("idle_ready", 32'(req_ready), 1);
                chk("idle_out",   32'({jk_en, done}), 0);
                if (req_valid) start_txn();
            end
        end
    end

    task automatic load(input logic [W-1:0] v);
        @(posedge clk); #2;
        load_en = 1; load_val = v;
        @(posedge clk); #2;
        load_en = 0;
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 50 && acc_cnt == n; i++) begin @(posedge clk); #2; end
        chk("accept_seen", 32'(acc_cnt != n), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && active; i++) begin @(posedge clk); #2; end
        chk("txn_ended", 32'(active), 0);
    endtask

    task automatic send(input logic [W-1:0] d, input logic m, input logic [7:0] mask);
        int n;
        n = acc_cnt;
        @(posedge clk); #2;
        ign_mask = mask; req_data = d; req_mode = m; req_valid = 1;
        wait_acc(n);
        req_valid = 0;
        wait_idle();
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2 clr_n = 1;

        // Direct set from 0000.
        load(4'b0000);
        send(4'b1010, 1'b0, 8'h00);
        chk("t1_j", 32'(r_j), 32'(4'b1010));
        chk("t1_k", 32'(r_k), 32'(4'b0101));
        chk("t1_done_cyc", 32'(r_done_t), 5);
        chk("t1_err", 32'(r_err), 0);
        chk("t1_ret", 32'(r_ret), 0);
        chk("t1_bank", 32'(bank_q), 32'(4'b1010));

        // Minimal toggle from 1100.
        load(4'b1100);
        send(4'b1010, 1'b1, 8'h00);
        chk("t2_j", 32'(r_j), 32'(4'b0110));
        chk("t2_k", 32'(r_k), 32'(4'b0110));
        chk("t2_done_cyc", 32'(r_done_t), 5);
        chk("t2_err", 32'(r_err), 0);
        chk("t2_bank", 32'(bank_q), 32'(4'b1010));

        // First pulse lost, one retry.
        load(4'b0000);
        send(4'b0001, 1'b1, 8'h01);
        chk("t3_j", 32'(r_j), 32'(4'b0001));
        chk("t3_k", 32'(r_k), 32'(4'b0001));
        chk("t3_pulses", 32'(r_pulses), 2);
        chk("t3_done_cyc", 32'(r_done_t), 9);
        chk("t3_err", 32'(r_err), 0);
        chk("t3_ret", 32'(r_ret), 1);

        // Stuck bank, retries exhausted.
        load(4'b0000);
        send(4'b1111, 1'b0, 8'hFF);
        chk("t4_pulses", 32'(r_pulses), 4);
        chk("t4_done_cyc", 32'(r_done_t), 17);
        chk("t4_err", 32'(r_err), 1);
        chk("t4_ret", 32'(r_ret), 3);

        // Back-to-back with req_valid held high.
        n = acc_cnt;
        @(posedge clk); #2;
        ign_mask = 8'h00; req_data = 4'b0011; req_mode = 1'b0; req_valid = 1;
        wait_acc(n);
        req_data = 4'b0101;
        n = acc_cnt;
        wait_acc(n);
        req_valid = 0;
        chk("b2b_spacing", 32'(acc_last - acc_prev), 6);
        wait_idle();
        chk("b2b_bank", 32'(bank_q), 32'(4'b0101));

        // Reset pulsed during WAIT.
        n = acc_cnt;
        @(posedge clk); #2;
        req_data = 4'b1001; req_mode = 1'b0; req_valid = 1;
        wait_acc(n);
        req_valid = 0;
        @(posedge clk); #2;
        clr_n = 0;
        #1;
        chk("abort_ready", 32'(req_ready), 1);
        chk("abort_outs", 32'({jk_en, done, err, jk_j, jk_k}), 0);
        repeat (2) @(posedge clk);
        #2 clr_n = 1;
        repeat (8) @(posedge clk);
        #2;
        chk("abort_no_txn", 32'(active), 0);
        send(4'b0110, 1'b0, 8'h00);
        chk("t6_done_cyc", 32'(r_done_t), 5);
        chk("t6_err", 32'(r_err), 0);
        chk("t6_bank", 32'(bank_q), 32'(4'b0110));

        // Randomized traffic with occasional lost pulses.
        repeat (40) begin
            if ($urandom_range(0, 3) == 0) load(W'($urandom));
            send(W'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/jk_drive_ctrl.md
# jk_drive_ctrl

Command-driven controller for a bank of WIDTH external JK flip-flops (`jkff` instances). It accepts a target register value over a valid/ready handshake and computes per-bit J/K excitation from a snapshot of the bank's current Q. It then pulses enable for one cycle, waits a settle window, and reads back Q, retrying on mismatch. It is the initiator side of the JK flip-flop j/k/enable/q interface and sits between sequencing logic and JK-based state registers.

## Interface
- WIDTH, 4: number of JK bits driven and monitored (≥1).
- SETTLE, 2: cycles to wait after the drive pulse before sampling feedback (≥1).
- MAX_RETRY, 3: re-drive attempts after the first drive before error (≥0).
- RW, $clog2(MAX_RETRY+1) (min 1): width of `retries`.

- clk  in  1  rising-edge clock.
- clr_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle, can accept.
- req_data  in  WIDTH  target Q value.
- req_mode  in  1  0 = direct set/reset, 1 = minimal toggle.
- jk_j  out  WIDTH  J drive to bank.
- jk_k  out  WIDTH  K drive to bank.
- jk_en  out  1  enable to bank, one-cycle pulse per drive.
- fb_q  in  WIDTH  Q feedback from bank.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies `done`: feedback never matched.
- retries  out  RW  re-drives used by the last transaction. Held until the next `done`.

## Operation
- States: IDLE, DRIVE, WAIT, CHECK, RESP.
- IDLE: req_ready=1. If req_valid, capture tgt<=req_data, mode<=req_mode, snap<=fb_q, rcnt<=0, and go to DRIVE.
- DRIVE (1 cycle): jk_en=1. Per bit i:
  - mode 0: J=tgt[i], K=~tgt[i].
  - mode 1: J=K=(tgt[i]^snap[i]).
  - Next state: WAIT.
- WAIT: hold SETTLE cycles with jk_en=0 and jk_j=jk_k=0, then go to CHECK.
- CHECK (1 cycle):
  - fb_q==tgt: go to RESP with ok.
  - Mismatch with rcnt<MAX_RETRY: rcnt++, snap<=fb_q, go to DRIVE.
  - Otherwise: go to RESP with fail.
- RESP (1 cycle): done=1, err=fail, retries<=rcnt. Next state: IDLE.
- jk_j, jk_k and jk_en are non-zero only in DRIVE. All three are 0 in every other state.
- req_ready is a decode of IDLE only. req_data and req_mode are ignored outside the accept cycle.
- MAX_RETRY=0: the first mismatch gives an immediate err.
- Async reset (clr_n=0), at any time including mid-transaction:
  - state=IDLE; tgt, snap, rcnt cleared.
  - jk_j=jk_k=0, jk_en=0, done=0, err=0, retries=0.
  - The aborted transaction produces no done.
  - req_ready reads 1 while in reset. Requesters must hold req_valid low until clr_n rises.

## Timing
- Accept on edge E0. DRIVE is the cycle after E0. WAIT follows for SETTLE cycles, then CHECK for 1 cycle, then RESP.
- First-try success: done is high in cycle E0+SETTLE+3 (cycle 5 at defaults). req_ready returns the following cycle.
- Each retry adds SETTLE+2 cycles.
- Worst case: done at E0+(MAX_RETRY+1)(SETTLE+2)+1 (cycle 17 at defaults).
- The bank is modelled as updating on the clk edge that ends the DRIVE cycle. CHECK samples fb_q combinationally at its closing edge.
- Back-to-back requests: minimum spacing is SETTLE+4 cycles (one idle/accept cycle between transactions).

## Test plan
- Defaults with an ideal 4-bit jkff model at Q=0000. Request 1010, mode 0 → in DRIVE: jk_j=1010, jk_k=0101, jk_en=1. done=1 and err=0 at cycle 5. retries=0. Bank=1010.
- Bank=1100, request 1010, mode 1 → in DRIVE: jk_j=jk_k=0110. Bank=1010, done at cycle 5, err=0.
- Model ignores the first enable pulse, request 0001 → one retry (in the retry DRIVE: jk_en=1, jk_j=jk_k=0001). done at cycle 9, err=0, retries=1.
- Stuck model (Q frozen at 0000), request 1111 → 4 drive pulses total. done=1 and err=1 at cycle 17. retries=3.
- req_valid held high continuously with two queued values (0011, then 0101) → accepts spaced 6 cycles apart. Exactly one done per request. No jk_en outside DRIVE.
- clr_n pulsed low during WAIT of a transaction → all outputs 0 immediately and no done. After release req_ready=1, and a new request 0110 completes normally at cycle 5.
